// File: rtl/i2c_master_seq.sv
// Single-byte I2C master: START, addr+R/W, ACK, one data byte, ACK, STOP; one command at a time.
// Accepts only in IDLE (cmd_ready_o); optional SCL-stall watchdog under `I2C_MASTER_TIMEOUT_EN.
module i2c_master_seq #(
   parameter int START_HOLD  = 2,
   parameter int STOP_HOLD   = 2,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic       i2c_core_clk_i,
   input  logic       i2c_core_rst_ni,
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic [6:0] cmd_addr_i,
   input  logic       cmd_rw_i,
   input  logic [7:0] cmd_wdata_i,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       scl_en_o,
   output logic       scl_low_o,
   output logic       sda_oe_o,
   output logic [7:0] rd_data_o,
   output logic       done_o,
   output logic       ack_err_o,
   output logic       timeout_o,
   output logic       busy_o
);

   typedef enum logic [3:0] {
      S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP_PREP, S_STOP, S_DONE
   } state_t;

   localparam logic [7:0] START_LIM = 8'(START_HOLD);
   localparam logic [7:0] STOP_LIM  = 8'(STOP_HOLD - 1);

   state_t     state_q, state_d;
   logic       scl_q, fall, rise;
   logic [7:0] shift_q, wdata_q, rd_data_q, hold_q;
   logic [2:0] bit_cnt_q;
   logic       rw_q, wrap_q, sda_oe_q, ack_err_q;
   logic       drive_bit, release_bit, wd_expire;

   assign fall = scl_q & ~scl_i;
   assign rise = ~scl_q & scl_i;

`ifdef I2C_MASTER_TIMEOUT_EN
   localparam logic [15:0] WD_LIM = 16'(TIMEOUT_CYC - 1);
   logic [15:0] wd_q;
   logic        wd_active, timeout_q;

   assign wd_active = state_q inside {S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP_PREP};
   assign wd_expire = wd_active & ~fall & ~rise & (wd_q == WD_LIM);

   always_ff @(posedge i2c_core_clk_i) begin
      if (!i2c_core_rst_ni) begin
         wd_q      <= 16'd0;
         timeout_q <= 1'b0;
      end else begin
         wd_q <= (!wd_active || fall || rise) ? 16'd0 : wd_q + 16'd1;
         if (state_q == S_IDLE && cmd_valid_i) timeout_q <= 1'b0;
         else if (wd_expire)                   timeout_q <= 1'b1;
      end
   end
   assign timeout_o = timeout_q;
`else
   assign wd_expire = 1'b0;
   assign timeout_o = 1'b0;
`endif

   always_ff @(posedge i2c_core_clk_i) begin
      if (!i2c_core_rst_ni) state_q <= S_IDLE;
      else                  state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (cmd_valid_i) state_d = S_START;
         S_START:     if (hold_q == START_LIM) state_d = S_ADDR;
         S_ADDR:      if (release_bit) state_d = S_ADDR_ACK;
         S_ADDR_ACK:  if (rise) state_d = sda_i ? S_STOP_PREP : S_DATA;
         S_DATA: begin
            if (rw_q) begin
               if (rise && bit_cnt_q == 3'd7) state_d = S_DATA_ACK;
            end else if (release_bit) begin
               state_d = S_DATA_ACK;
            end
         end
         S_DATA_ACK:  if (rise) state_d = S_STOP_PREP;
         S_STOP_PREP: if (rise && sda_oe_q) state_d = S_STOP;
         S_STOP:      if (hold_q == STOP_LIM) state_d = S_DONE;
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
      if (wd_expire) state_d = S_DONE;
   end

   always_comb begin
      cmd_ready_o = (state_q == S_IDLE);
      busy_o      = (state_q != S_IDLE);
      scl_en_o    = state_q inside {S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP_PREP};
      scl_low_o   = (state_q == S_START) && (hold_q == START_LIM);
      done_o      = (state_q == S_DONE);
      drive_bit   = scl_low_o ||
                    (fall && !wrap_q && (state_q == S_ADDR || (state_q == S_DATA && !rw_q)));
      release_bit = fall && wrap_q && (state_q == S_ADDR || (state_q == S_DATA && !rw_q));
   end

   always_ff @(posedge i2c_core_clk_i) begin
      if (!i2c_core_rst_ni) begin
         scl_q     <= 1'b1;
         shift_q   <= 8'h00;
         wdata_q   <= 8'h00;
         rd_data_q <= 8'h00;
         hold_q    <= 8'h00;
         bit_cnt_q <= 3'd0;
         rw_q      <= 1'b0;
         wrap_q    <= 1'b0;
         sda_oe_q  <= 1'b0;
         ack_err_q <= 1'b0;
      end else begin
         scl_q <= scl_i;
         case (state_q)
            S_IDLE: if (cmd_valid_i) begin
               shift_q   <= {cmd_addr_i, cmd_rw_i};
               rw_q      <= cmd_rw_i;
               wdata_q   <= cmd_wdata_i;
               ack_err_q <= 1'b0;
               sda_oe_q  <= 1'b1;
               hold_q    <= 8'h00;
               bit_cnt_q <= 3'd0;
               wrap_q    <= 1'b0;
            end
            S_START: begin
               if (hold_q != START_LIM) hold_q <= hold_q + 8'd1;
               // The forced SCL low counts as the first fall; pre-clear scl_q so the
               // real falling edge that follows is not seen as a second one.
               else scl_q <= 1'b0;
            end
            S_ADDR_ACK: if (rise) begin
               if (sda_i) ack_err_q <= 1'b1;
               else begin
                  shift_q   <= rw_q ? 8'h00 : wdata_q;
                  bit_cnt_q <= 3'd0;
               end
            end
            S_DATA: if (rw_q && rise) begin
               shift_q   <= {shift_q[6:0], sda_i};
               bit_cnt_q <= bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) rd_data_q <= {shift_q[6:0], sda_i};
            end
            S_DATA_ACK:  if (rise && sda_i && !rw_q) ack_err_q <= 1'b1;
            S_STOP_PREP: begin
               if (fall) sda_oe_q <= 1'b1;
               if (rise && sda_oe_q) hold_q <= 8'h00;
            end
            S_STOP: begin
               if (hold_q == STOP_LIM) sda_oe_q <= 1'b0;
               else                    hold_q   <= hold_q + 8'd1;
            end
            default: ;
         endcase
         if (drive_bit) begin
            sda_oe_q  <= ~shift_q[7];
            shift_q   <= {shift_q[6:0], 1'b0};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            wrap_q    <= (bit_cnt_q == 3'd7);
         end
         if (release_bit) begin
            sda_oe_q <= 1'b0;
            wrap_q   <= 1'b0;
         end
         if (wd_expire) sda_oe_q <= 1'b0;
      end
   end

   assign sda_oe_o  = sda_oe_q;
   assign rd_data_o = rd_data_q;
   assign ack_err_o = ack_err_q;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: SCL generator stand-in, bit-level I2C slave/monitor, random commands.
module tb_i2c_master_seq;
   localparam int HALF = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0, cmd_rw = 1'b0;
   logic [6:0] cmd_addr = 7'h00;
   logic [7:0] cmd_wdata = 8'h00;
   logic       scl = 1'b1, sda_bus;
   logic       cmd_ready, scl_en, scl_low, sda_oe, done, ack_err, timeout, busy;
   logic [7:0] rd_data;

   always #5 clk = ~clk;

   i2c_master_seq #(.START_HOLD(2), .STOP_HOLD(2), .TIMEOUT_CYC(16)) dut (
      .i2c_core_clk_i(clk), .i2c_core_rst_ni(rst_n),
      .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
      .cmd_rw_i(cmd_rw), .cmd_wdata_i(cmd_wdata), .scl_i(scl), .sda_i(sda_bus),
      .scl_en_o(scl_en), .scl_low_o(scl_low), .sda_oe_o(sda_oe), .rd_data_o(rd_data),
      .done_o(done), .ack_err_o(ack_err), .timeout_o(timeout), .busy_o(busy)
   );

   // SCL source: forced low by scl_low, parked high when disabled, else toggles every HALF cycles
   logic scl_stuck = 1'b0;
   int   scl_cnt = 0;
   always @(posedge clk) begin
      if (scl_stuck)    scl <= 1'b0;
      else if (scl_low) begin scl <= 1'b0; scl_cnt <= 0; end
      else if (!scl_en) begin scl <= 1'b1; scl_cnt <= 0; end
      else if (scl_cnt == HALF - 1) begin scl <= ~scl; scl_cnt <= 0; end
      else scl_cnt <= scl_cnt + 1;
   end

   // Open-drain bus and a slave that answers according to the cfg variables
   logic       slave_low = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1;
   logic       ack_addr_cfg = 1'b1, ack_data_cfg = 1'b1;
   logic [7:0] rd_cfg = 8'h00;
   logic       bits [0:31];
   int         bitn = 0, starts = 0, stops = 0, dones = 0, accepts = 0, cyc = 0, last_edge = 0;

   assign sda_bus = ~(sda_oe | slave_low);

   function automatic logic slave_drive(input int n);
      if (n == 8) return ack_addr_cfg;
      if (ack_addr_cfg && bits[7] && n >= 9 && n <= 16) return ~rd_cfg[16 - n];
      if (ack_addr_cfg && !bits[7] && n == 17) return ack_data_cfg;
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      prev_scl <= scl;
      prev_sda <= sda_bus;
      if (scl != prev_scl) last_edge <= cyc;
      if (done) dones <= dones + 1;
      if (cmd_valid && cmd_ready) accepts <= accepts + 1;
      if (!rst_n) slave_low <= 1'b0;
      else if (prev_scl && scl && prev_sda && !sda_bus) begin bitn <= 0; starts <= starts + 1; end
      else if (prev_scl && scl && !prev_sda && sda_bus) stops <= stops + 1;
      else if (!prev_scl && scl) begin
         if (bitn < 32) bits[bitn] <= sda_bus;
         bitn <= bitn + 1;
      end
      else if (prev_scl && !scl) slave_low <= slave_drive(bitn);
   end

   int         n_chk = 0, n_pass = 0;
   logic [7:0] exp_rd = 8'h00;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!done && k < 3000) begin @(negedge clk); k++; end
      chk(tag, 32'(k < 3000), 1);
   endtask

   // One full command checked against the I2C-level expectation of the byte exchange
   task automatic run_cmd(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                          input logic aa, input logic ad, input logic [7:0] rb);
      int d0, s0;
      logic exp_err;
      logic [7:0] ab, db;
      @(negedge clk);
      ack_addr_cfg = aa; ack_data_cfg = ad; rd_cfg = rb;
      cmd_addr = a; cmd_rw = rw; cmd_wdata = wd;
      chk("ready_idle", 32'(cmd_ready), 1);
      d0 = dones; s0 = stops;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      chk("busy", 32'(busy), 1);
      wait_done("done_seen");
      exp_err = !aa || (!rw && !ad);
      if (rw && aa) exp_rd = rb;
      chk("ack_err", 32'(ack_err), 32'(exp_err));
      chk("rd_data", 32'(rd_data), 32'(exp_rd));
      chk("timeout", 32'(timeout), 0);
      repeat (4) @(negedge clk);
      chk("done_pulses", 32'(dones - d0), 1);
      chk("stop_seen", 32'(stops - s0), 1);
      chk("rises", 32'(bitn), aa ? 19 : 10);
      for (int i = 0; i < 8; i++) begin ab[7 - i] = bits[i]; db[7 - i] = bits[9 + i]; end
      chk("addr_byte", 32'(ab), 32'({a, rw}));
      chk("addr_ack_bit", 32'(bits[8]), 32'(!aa));
      if (aa) begin
         chk("data_byte", 32'(db), rw ? 32'(rb) : 32'(wd));
         chk("data_ack_bit", 32'(bits[17]), rw ? 1 : 32'(!ad));
      end
      chk("sda_idle", 32'(sda_bus), 1);
   endtask

   initial begin
      int base, k, rdy_hi, s0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(cmd_ready), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_outs", 32'({scl_en, scl_low, sda_oe, done, ack_err, timeout}), 0);
      chk("rst_rd", 32'(rd_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      run_cmd(7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00);
      run_cmd(7'h51, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C);
      run_cmd(7'h33, 1'b1, 8'h00, 1'b0, 1'b1, 8'hFF);
      run_cmd(7'h12, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00);
      for (int i = 0; i < 10; i++)
         run_cmd(7'($urandom), 1'($urandom), 8'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0), 8'($urandom));

      // Back-to-back: valid held high, first command NACKed, second must clear ack_err
      @(negedge clk);
      base = accepts;
      ack_addr_cfg = 1'b0; cmd_addr = 7'h2A; cmd_rw = 1'b0; cmd_wdata = 8'h11;
      cmd_valid = 1'b1;
      k = 0;
      while (accepts == base && k < 100) begin @(negedge clk); k++; end
      cmd_addr = 7'h3B; cmd_wdata = 8'hC3;
      rdy_hi = 0; k = 0;
      while (!done && k < 3000) begin if (cmd_ready) rdy_hi++; @(negedge clk); k++; end
      chk("b2b_ready_low", 32'(rdy_hi), 0);
      chk("b2b_err_first", 32'(ack_err), 1);
      chk("b2b_one_accept", 32'(accepts - base), 1);
      ack_addr_cfg = 1'b1; ack_data_cfg = 1'b1;
      k = 0;
      while (accepts == base + 1 && k < 100) begin @(negedge clk); k++; end
      cmd_valid = 1'b0;
      chk("b2b_second_accept", 32'(accepts - base), 2);
      chk("b2b_err_cleared", 32'(ack_err), 0);
      wait_done("b2b_done");
      chk("b2b_err_final", 32'(ack_err), 0);
      repeat (4) @(negedge clk);

      // Reset while the data byte is on the wire
      s0 = starts;
      cmd_addr = 7'h44; cmd_rw = 1'b0; cmd_wdata = 8'h96;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      k = 0;
      while (!(starts > s0 && bitn == 13) && k < 3000) begin @(negedge clk); k++; end
      chk("reach_data_bit4", 32'(k < 3000), 1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      exp_rd = 8'h00;
      chk("midrst_ready", 32'(cmd_ready), 1);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_outs", 32'({scl_en, scl_low, sda_oe, done, ack_err, timeout}), 0);
      chk("midrst_rd", 32'(rd_data), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      run_cmd(7'h51, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC7);

`ifdef I2C_MASTER_TIMEOUT_EN
      s0 = starts;
      cmd_addr = 7'h60; cmd_rw = 1'b0; cmd_wdata = 8'h00;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
      k = 0;
      while (!(starts > s0 && bitn == 3) && k < 3000) begin @(negedge clk); k++; end
      scl_stuck = 1'b1;
      wait_done("to_done");
      chk("to_flag", 32'(timeout), 1);
      chk("to_sda_rel", 32'(sda_oe), 0);
      chk("to_delay", 32'((cyc - last_edge) >= 14 && (cyc - last_edge) <= 20), 1);
      @(negedge clk);
      scl_stuck = 1'b0;
      repeat (4) @(negedge clk);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/i2c_master_seq.md
Name: i2c_master_seq

Overview:
- Single-byte I2C master sequencer that drives `clock_generator` through its `scl_en_i`/`scl_low_i` inputs and controls SDA as an open-drain line.
- Per accepted command it performs: START, 7-bit address + R/W, ACK check, one data byte (write or read), ACK phase, STOP.
- Sits between the register/host interface and `clock_generator` plus the SDA pad.

Parameters:
- START_HOLD, 2, core cycles SDA held low with SCL high before the first SCL fall (>=1).
- STOP_HOLD, 2, core cycles SCL held high with SDA low before SDA release (>=1).
- TIMEOUT_CYC, 64, watchdog limit in core cycles without an SCL edge (used only with the optional feature).

Ports:
- i2c_core_clk_i  in  1  i2c core clock, the only clock.
- i2c_core_rst_ni  in  1  reset; synchronous, active-low.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  high exactly when state is IDLE.
- cmd_addr_i  in  7  slave address.
- cmd_rw_i  in  1  0 = write, 1 = read.
- cmd_wdata_i  in  8  write byte.
- scl_i  in  1  SCL as produced by `clock_generator` (`i2c_scl_o`).
- sda_i  in  1  sampled SDA bus line.
- scl_en_o  out  1  to `clock_generator` `scl_en_i`.
- scl_low_o  out  1  to `clock_generator` `scl_low_i`.
- sda_oe_o  out  1  1 = pull SDA low, 0 = release.
- rd_data_o  out  8  received byte.
- done_o  out  1  one-cycle completion pulse.
- ack_err_o  out  1  NACK seen on the last command.
- timeout_o  out  1  watchdog abort flag on the last command.
- busy_o  out  1  state is not IDLE.

Behaviour:
- Reset (`i2c_core_rst_ni` = 0 at a clock edge):
  - State goes to IDLE.
  - `scl_en_o`, `scl_low_o`, `sda_oe_o`, `done_o`, `ack_err_o`, `timeout_o`, `busy_o` = 0.
  - `rd_data_o` = 0x00; bit counter = 0; `scl_q` = 1.
  - Reset mid-transfer aborts immediately; no STOP is generated.
- Edge detect: register `scl_i` into `scl_q`.
  - `fall` = `scl_q` & ~`scl_i`.
  - `rise` = ~`scl_q` & `scl_i`.
- Handshake:
  - A command is accepted on a cycle where `cmd_valid_i` & `cmd_ready_o`.
  - On accept: latch shift register = {`cmd_addr_i`, `cmd_rw_i`}, latch `cmd_rw_i` and `cmd_wdata_i`; clear `ack_err_o` and `timeout_o`; go to START.
  - `cmd_valid_i` is ignored while busy.
- START:
  - `sda_oe_o` = 1 for START_HOLD cycles with `scl_en_o` = 0 (SCL high).
  - Then assert `scl_low_o` for one cycle (forces SCL low; this is treated as the first fall), then `scl_en_o` = 1.
  - `scl_en_o` stays 1 until STOP. Go to ADDR.
- ADDR:
  - On each fall, drive `sda_oe_o` = ~shift[7], shift left, bit counter +1.
  - After 8 bits, on the next fall release SDA; go to ADDR_ACK.
- ADDR_ACK: on rise, sample `sda_i`.
  - `sda_i` = 1: set `ack_err_o` and go to STOP_PREP.
  - `sda_i` = 0: load the data phase (write: shift = `cmd_wdata_i`); go to DATA.
- DATA, write:
  - Same bit driving as ADDR.
  - After 8 bits, release SDA; go to DATA_ACK.
  - In DATA_ACK, sample `sda_i` on rise; a NACK sets `ack_err_o`.
- DATA, read:
  - SDA released; on each rise shift `sda_i` into the receive register, MSB first.
  - After the 8th rise, go to DATA_ACK; the master sends NACK (SDA released) for that bit.
  - `rd_data_o` updates on the 8th rise.
- STOP_PREP:
  - On the next fall, `sda_oe_o` = 1.
  - On the following rise, `scl_en_o` = 0 (SCL remains high); go to STOP.
- STOP:
  - Hold `sda_oe_o` = 1 for STOP_HOLD cycles, then `sda_oe_o` = 0; go to DONE.
- DONE: `done_o` = 1 for one cycle; go to IDLE.
- Boundary cases:
  - Bit counter is 3 bits; it wraps 7→0, and the phase change happens on the wrap.
  - `fall` and `rise` cannot coincide.
  - `ack_err_o`, `timeout_o` and `rd_data_o` hold until the next accept.

Optional Feature:
- Macro: I2C_MASTER_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog clears on every SCL edge and on entering START.
  - It counts while in ADDR, ADDR_ACK, DATA, DATA_ACK or STOP_PREP.
  - When the count reaches TIMEOUT_CYC: set `timeout_o`, release SDA, `scl_en_o` = 0, go directly to DONE (`done_o` pulse, no STOP).
- Undefined: no watchdog logic; `timeout_o` is tied to 0.

Test Plan:
- Write: addr 0x50, rw 0, wdata 0xA5, slave ACKs both phases.
  - SDA bit stream 0xA0 then 0xA5.
  - `done_o` pulses once; `ack_err_o` = 0.
  - STOP seen: SDA rises while SCL = 1.
- Read: addr 0x51, slave drives 0x3C after address ACK -> `rd_data_o` = 0x3C at `done_o`; master NACK bit has SDA released.
- Address NACK: `sda_i` = 1 in ADDR_ACK.
  - No data bits clocked; STOP generated.
  - `ack_err_o` = 1, `done_o` pulses.
- Back-to-back: `cmd_valid_i` held high for 2 commands.
  - Second command accepted only after `done_o` (`cmd_ready_o` = 0 throughout the first).
  - `ack_err_o` cleared on the second accept.
- Reset asserted during DATA bit 4 -> next cycle all outputs at reset values, `cmd_ready_o` = 1.
- With I2C_MASTER_TIMEOUT_EN, TIMEOUT_CYC = 16, and `scl_i` forced stuck low after START -> `timeout_o` = 1 and a `done_o` pulse 16 cycles after the last edge, `sda_oe_o` = 0.
